// File: rtl/pwm_if.sv
// Signal bundle between a PWM controller and the pwm_generator leaf.
// The master drives the requested on-time; the generator (slave) drives the waveform.
interface pwm_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] PWM_ontime;
  logic             PWM_out;
  logic             period_start;

  modport master (output PWM_ontime, input PWM_out, input period_start);
  modport slave  (input PWM_ontime, output PWM_out, output period_start);
endinterface

// File: rtl/pwm_generator.sv
// Free-running single-channel PWM with a period of 2**WIDTH clocks.
// The duty cycle is latched only at the period boundary, so the output never glitches.
module pwm_generator #(
  parameter int WIDTH = 8
) (
  input  logic  clk,
  input  logic  reset,
  pwm_if.slave  pwm
);

  localparam logic [WIDTH-1:0] CNT_ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0] cnt;
  logic [WIDTH-1:0] duty_q;
  logic [WIDTH-1:0] duty_eff;
  logic             at_start;

  assign at_start = (cnt == '0);

  // The first clock of a period uses the live request so the new duty
  // applies to that very period; every other clock uses the latched copy.
  always_comb begin
    duty_eff = duty_q;
    if (at_start) begin
      duty_eff = pwm.PWM_ontime;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt              <= '0;
      duty_q           <= '0;
      pwm.PWM_out      <= 1'b0;
      pwm.period_start <= 1'b0;
    end else begin
      cnt              <= cnt + CNT_ONE;
      if (at_start) begin
        duty_q <= pwm.PWM_ontime;
      end
      pwm.PWM_out      <= (cnt < duty_eff);
      pwm.period_start <= at_start;
    end
  end

endmodule

// File: tb/tb_pwm_generator.sv
// Self-checking bench for pwm_generator: per-clock waveform model plus
// per-period high-count and period-spacing scoreboard.
module tb_pwm_generator;

  localparam int WIDTH  = 8;
  localparam int PERIOD = 1 << WIDTH;

  logic clk = 1'b0;
  logic reset;

  pwm_if #(.WIDTH(WIDTH)) pif ();

  pwm_generator #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .reset (reset),
    .pwm   (pif)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state: clocks since reset release and duty of current period.
  int t        = 0;
  int cur_duty = 0;

  // Period scoreboard state.
  bit in_period = 1'b0;
  int hi_cnt    = 0;
  int per_len   = 0;
  int per_duty  = 0;

  task automatic check_val(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at time %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic step(input logic rst_v, input logic [WIDTH-1:0] on_v);
    int r;
    int exp_out;
    int exp_ps;
    reset          = rst_v;
    pif.PWM_ontime = on_v;
    @(posedge clk);
    if (rst_v) begin
      t       = 0;
      exp_out = 0;
      exp_ps  = 0;
    end else begin
      r = t % PERIOD;
      if (r == 0) cur_duty = int'(on_v);
      exp_out = (r < cur_duty) ? 1 : 0;
      exp_ps  = (r == 0) ? 1 : 0;
      t++;
    end
    #1;
    check_val("pwm_out", int'(pif.PWM_out), exp_out);
    check_val("period_start", int'(pif.period_start), exp_ps);

    if (rst_v) begin
      in_period = 1'b0;
    end else begin
      if (pif.period_start === 1'b1) begin
        if (in_period) begin
          check_val("period_high_count", hi_cnt, per_duty);
          check_val("period_spacing", per_len, PERIOD);
        end
        in_period = 1'b1;
        hi_cnt    = 0;
        per_len   = 0;
        per_duty  = int'(on_v);
      end
      if (in_period) begin
        per_len++;
        if (pif.PWM_out === 1'b1) hi_cnt++;
      end
    end
  endtask

  task automatic do_reset(input logic [WIDTH-1:0] on_v);
    step(1'b1, on_v);
    step(1'b1, on_v);
  endtask

  initial begin
    int total;
    int hold;
    logic [WIDTH-1:0] on_r;

    reset          = 1'b1;
    pif.PWM_ontime = '0;

    // Zero duty: output stays low through two full periods.
    do_reset(8'h00);
    for (int i = 0; i < 2 * PERIOD; i++) step(1'b0, 8'h00);

    // Maximum duty applied right at release: 255 high, 1 low.
    do_reset(8'hFF);
    for (int i = 0; i < 3 * PERIOD + 1; i++) step(1'b0, 8'hFF);

    // Short pulse, checks 15 high / 241 low and 256-clock spacing.
    do_reset(8'h0F);
    for (int i = 0; i < 3 * PERIOD + 1; i++) step(1'b0, 8'h0F);

    // Mid-period change 0x80 -> 0x10 at cnt=0x40 must not affect the current period.
    do_reset(8'h80);
    for (int i = 0; i < 3 * PERIOD + 1; i++) step(1'b0, (i < 8'h40) ? 8'h80 : 8'h10);

    // Reset at cnt=0x30 while high, then restart with a new duty.
    do_reset(8'h80);
    for (int i = 0; i < 8'h30; i++) step(1'b0, 8'h80);
    check_val("high_before_abort", int'(pif.PWM_out), 1);
    step(1'b1, 8'h80);
    step(1'b0, 8'h20);
    for (int i = 0; i < 2 * PERIOD + 1; i++) step(1'b0, 8'h20);

    // Random duty requests held for a random number of clocks.
    do_reset(8'h00);
    total = 0;
    while (total < 60000) begin
      on_r = WIDTH'($urandom_range(0, PERIOD - 1));
      case ($urandom_range(0, 9))
        0: on_r = '0;
        1: on_r = '1;
        default: ;
      endcase
      hold = int'($urandom_range(200, 1000));
      for (int i = 0; i < hold; i++) step(1'b0, on_r);
      total += hold;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
